// File: rtl/mult_div_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: radix-2 Booth multiply and restoring divide,
// with the 64-bit result presented as HI/LO words and strobes on completion.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             hi_load,
    output logic             lo_load,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4,
        S_DZ   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     mcand_ext_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Next-state, datapath step and output-register next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        qm1_d       = qm1_q;
        mcand_d     = mcand_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        mcand_ext_s = {mcand_q[WIDTH-1], mcand_q};
        sum_s       = acc_q;
        shifted_s   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial_s     = shifted_s - {1'b0, mcand_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = 6'd0;
                    qm1_d = 1'b0;
                    acc_d = '0;
                    if (!op) begin
                        state_d = S_MULT;
                        mq_d    = src_b;
                        mcand_d = src_a;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                    end else if (src_b != '0) begin
                        state_d = S_DIV;
                        mq_d    = magnitude(src_a);
                        mcand_d = magnitude(src_b);
                        negq_d  = src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        negr_d  = src_a[WIDTH-1];
                    end else begin
                        state_d = S_DZ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                // Accumulator carries one guard bit so -2^31 multiplicands cannot overflow
                case ({mq_q[0], qm1_q})
                    2'b01:   sum_s = acc_q + mcand_ext_s;
                    2'b10:   sum_s = acc_q - mcand_ext_s;
                    default: sum_s = acc_q;
                endcase
                acc_d = {sum_s[WIDTH], sum_s[WIDTH:1]};
                mq_d  = {sum_s[0], mq_q[WIDTH-1:1]};
                qm1_d = mq_q[0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_DIV: begin
                if (trial_s[WIDTH]) begin
                    acc_d = shifted_s;
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = trial_s;
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                if (negq_q) begin
                    mq_d = -mq_q;
                end else begin
                    mq_d = mq_q;
                end
                if (negr_q) begin
                    acc_d = {1'b0, -acc_q[WIDTH-1:0]};
                end else begin
                    acc_d = acc_q;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_DZ:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        dz_d   = (state_d == S_DZ);
        // Result words are latched on entry to DONE so they are valid in the DONE cycle itself
        if (state_d == S_DONE) begin
            hi_d = acc_d[WIDTH-1:0];
            lo_d = mq_d;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_load  = done_q;
    assign lo_load  = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed spec cases plus randomized operands
// checked against a 64-bit arithmetic reference model.
module tb_mult_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        hi_load;
    logic        lo_load;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    // Observations gathered by do_op
    int          obs_done_cyc;
    int          obs_done_cnt;
    int          obs_dz_cyc;
    int          obs_dz_cnt;
    int          obs_load_bad;
    int          obs_busy_bad;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;
    logic [31:0] obs_fin_hi;
    logic [31:0] obs_fin_lo;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    always #5 clk = ~clk;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .hi_load(hi_load), .lo_load(lo_load), .hi_out(hi_out),
        .lo_out(lo_out), .div_zero(div_zero)
    );

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}; longint division truncates toward zero
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one start (cycle 0) and observe cycles 1..ncyc; extra start pulses in cycles ign1/ign2
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int ncyc, input int ign1, input int ign2);
        int exp_last;
        exp_last = o ? ((b == 32'd0) ? 1 : 34) : 33;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_dz_cyc = -1; obs_dz_cnt = 0;
        obs_load_bad = 0; obs_busy_bad = 0; obs_hi = 32'hx; obs_lo = 32'hx;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == ign1 || c == ign2) begin
                start = 1'b1; op = 1'b1; src_a = $urandom; src_b = 32'd0;
            end else begin
                start = 1'b0; op = $urandom_range(1, 0); src_a = $urandom; src_b = $urandom;
            end
            @(negedge clk);
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_hi = hi_out; obs_lo = lo_out;
                end
            end
            if (div_zero) begin
                obs_dz_cnt++;
                if (obs_dz_cyc < 0) obs_dz_cyc = c;
            end
            if (hi_load !== done || lo_load !== done) obs_load_bad++;
            if (busy !== (c <= exp_last)) obs_busy_bad++;
            obs_fin_hi = hi_out; obs_fin_lo = lo_out;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; src_a = 32'd0; src_b = 32'd0;
        #12;
        checks++;
        if ({busy, done, hi_load, lo_load, div_zero, hi_out, lo_out} !== 69'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b hl=%b ll=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, hi_load, lo_load, div_zero, hi_out, lo_out);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_directed();
        logic [31:0] ta [3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] tb [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] eh [3] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000000};
        logic [31:0] el [3] = '{32'hFFFFFFEB, 32'h00000000, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, ta[i], tb[i], 36, 0, 0);
            checks++;
            if (obs_done_cyc != 33 || obs_done_cnt != 1) begin
                errors++;
                $display("FAIL mult_timing[%0d]: done cycle %0d count %0d, want 33 / 1", i, obs_done_cyc, obs_done_cnt);
            end
            checks++;
            if (obs_hi !== eh[i] || obs_lo !== el[i]) begin
                errors++;
                $display("FAIL mult_result[%0d]: got %h_%h, want %h_%h", i, obs_hi, obs_lo, eh[i], el[i]);
            end
            checks++;
            if (obs_load_bad != 0 || obs_busy_bad != 0 || obs_dz_cnt != 0) begin
                errors++;
                $display("FAIL mult_strobes[%0d]: load_bad=%0d busy_bad=%0d dz=%0d, want 0/0/0",
                         i, obs_load_bad, obs_busy_bad, obs_dz_cnt);
            end
            last_hi = eh[i]; last_lo = el[i];
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] ta [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] tb [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] eh [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        logic [31:0] el [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, ta[i], tb[i], 37, 0, 0);
            checks++;
            if (obs_done_cyc != 34 || obs_done_cnt != 1) begin
                errors++;
                $display("FAIL div_timing[%0d]: done cycle %0d count %0d, want 34 / 1", i, obs_done_cyc, obs_done_cnt);
            end
            checks++;
            if (obs_hi !== eh[i] || obs_lo !== el[i]) begin
                errors++;
                $display("FAIL div_result[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, obs_hi, obs_lo, eh[i], el[i]);
            end
            checks++;
            if (obs_load_bad != 0 || obs_busy_bad != 0 || obs_dz_cnt != 0) begin
                errors++;
                $display("FAIL div_strobes[%0d]: load_bad=%0d busy_bad=%0d dz=%0d, want 0/0/0",
                         i, obs_load_bad, obs_busy_bad, obs_dz_cnt);
            end
            last_hi = eh[i]; last_lo = el[i];
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] e;
        do_op(1'b1, 32'd5, 32'd0, 1, 0, 0);
        checks++;
        if (obs_dz_cyc != 1 || obs_dz_cnt != 1 || obs_done_cnt != 0 || obs_load_bad != 0 || obs_busy_bad != 0) begin
            errors++;
            $display("FAIL div_zero_flags: dz cycle %0d count %0d done %0d load_bad %0d busy_bad %0d, want 1/1/0/0/0",
                     obs_dz_cyc, obs_dz_cnt, obs_done_cnt, obs_load_bad, obs_busy_bad);
        end
        checks++;
        if (obs_fin_hi !== last_hi || obs_fin_lo !== last_lo) begin
            errors++;
            $display("FAIL div_zero_hold: got hi=%h lo=%h, want hi=%h lo=%h", obs_fin_hi, obs_fin_lo, last_hi, last_lo);
        end
        // Start in cycle 2 must be accepted
        do_op(1'b0, 32'd9, 32'hFFFFFFF0, 36, 0, 0);
        e = ref_mult(32'd9, 32'hFFFFFFF0);
        checks++;
        if (obs_done_cyc != 33 || obs_busy_bad != 0 || {obs_hi, obs_lo} !== e || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_followup: done cycle %0d busy_bad %0d got %h_%h, want 33 / 0 / %h",
                     obs_done_cyc, obs_busy_bad, obs_hi, obs_lo, e);
        end
        last_hi = e[63:32]; last_lo = e[31:0];
    endtask

    task automatic test_random_mult();
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 == 1) a = $urandom_range(200, 0) - 100;
            if (i % 4 == 2) b = 32'h80000000;
            do_op(1'b0, a, b, 33, 0, 0);
            e = ref_mult(a, b);
            checks++;
            if (obs_done_cyc != 33 || obs_busy_bad != 0 || {obs_hi, obs_lo} !== e) begin
                errors++;
                $display("FAIL rand_mult: %h*%h done cycle %0d busy_bad %0d got %h_%h, want 33 / 0 / %h",
                         a, b, obs_done_cyc, obs_busy_bad, obs_hi, obs_lo, e);
            end
            last_hi = e[63:32]; last_lo = e[31:0];
        end
    endtask

    task automatic test_random_div();
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? ($urandom_range(40, 1) * ((i % 4 == 0) ? 32'd1 : 32'hFFFFFFFF)) : $urandom;
            if (b == 32'd0) b = 32'd3;
            if (i == 5) a = 32'h80000000;
            do_op(1'b1, a, b, 34, 0, 0);
            e = ref_div(a, b);
            checks++;
            if (obs_done_cyc != 34 || obs_busy_bad != 0 || {obs_hi, obs_lo} !== e) begin
                errors++;
                $display("FAIL rand_div: %h/%h done cycle %0d busy_bad %0d got hi=%h lo=%h, want 34 / 0 / %h",
                         a, b, obs_done_cyc, obs_busy_bad, obs_hi, obs_lo, e);
            end
            last_hi = e[63:32]; last_lo = e[31:0];
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] a, b;
        logic [63:0] e;
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 33, 5, 20);
        e = ref_mult(a, b);
        checks++;
        if (obs_done_cnt != 1 || obs_done_cyc != 33 || obs_dz_cnt != 0 || {obs_hi, obs_lo} !== e) begin
            errors++;
            $display("FAIL ignored_start: done count %0d cycle %0d dz %0d got %h_%h, want 1 / 33 / 0 / %h",
                     obs_done_cnt, obs_done_cyc, obs_dz_cnt, obs_hi, obs_lo, e);
        end
        // Start in cycle 34 must be accepted
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 36, 0, 0);
        e = ref_mult(a, b);
        checks++;
        if (obs_done_cyc != 33 || obs_done_cnt != 1 || {obs_hi, obs_lo} !== e) begin
            errors++;
            $display("FAIL start_after_done: done cycle %0d count %0d got %h_%h, want 33 / 1 / %h",
                     obs_done_cyc, obs_done_cnt, obs_hi, obs_lo, e);
        end
        last_hi = e[63:32]; last_lo = e[31:0];
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom_range(1000, 1);
            do_op(1'b1, a, b, 34, 0, 0);
            e = ref_div(a, b);
            checks++;
            if (obs_done_cyc != 34 || obs_done_cnt != 1 || {obs_hi, obs_lo} !== e) begin
                errors++;
                $display("FAIL back_to_back_div[%0d]: done cycle %0d count %0d got hi=%h lo=%h, want 34 / 1 / %h",
                         i, obs_done_cyc, obs_done_cnt, obs_hi, obs_lo, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dcnt;
        do_op(1'b1, 32'h12345678, 32'd7, 9, 0, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0", busy, done, hi_out, lo_out);
        end
        @(negedge clk); reset = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || hi_load || lo_load || div_zero || busy) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d active cycles after release, want 0", dcnt);
        end
        @(posedge clk); #1;
        do_op(1'b0, 32'd3, 32'd4, 34, 0, 0);
        checks++;
        if (obs_done_cyc != 33 || obs_hi !== 32'd0 || obs_lo !== 32'd12) begin
            errors++;
            $display("FAIL reset_fresh_mult: done cycle %0d got hi=%h lo=%h, want 33 / 0 / 0000000c",
                     obs_done_cyc, obs_hi, obs_lo);
        end
    endtask

    initial begin
        last_hi = 32'd0; last_lo = 32'd0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_random_mult();
        test_random_div();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Multi-cycle sequencer for the signed multiply and divide resource of the multicycle MIPS core. The main control unit issues one `start` pulse with an operation select. The block captures the A/B operands, iterates one step per clock, and then presents the 64-bit result as separate HI and LO words with write strobes for the HI/LO registers. It also flags divide-by-zero so the control FSM can take the exception path, and it holds `busy` so the control unit can stall in its wait state.

## Interface
- `WIDTH`, 32: operand width; the HI/LO result words are also `WIDTH` bits each.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request pulse; honoured only in IDLE.
- `op`  in  1  operation select: 0 = MULT, 1 = DIV; sampled with `start`.
- `src_a`  in  WIDTH  multiplicand or dividend (register A value); sampled with `start`.
- `src_b`  in  WIDTH  multiplier or divisor (register B value); sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse; `hi_out`/`lo_out` valid.
- `hi_load`  out  1  HI register write strobe; equal to `done`.
- `lo_load`  out  1  LO register write strobe; equal to `done`.
- `hi_out`  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- `lo_out`  out  WIDTH  MULT: product[31:0]; DIV: quotient.
- `div_zero`  out  1  one-cycle pulse; the DIV divisor was 0.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE, DZ.
- Transitions:
  - IDLE + `start` & `op`=0: go to MULT.
  - IDLE + `start` & `op`=1 & `src_b`≠0: go to DIV.
  - IDLE + `start` & `op`=1 & `src_b`=0: go to DZ.
  - MULT after 32 steps: go to DONE.
  - DIV after 32 steps: go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
  - DZ: go to IDLE.
- Iteration counter: 6 bits, cleared on accept, incremented once per MULT/DIV cycle; the last step is at count 31.
- MULT: radix-2 Booth on a {acc[WIDTH], multiplier[WIDTH], q-1} register.
  - Each step adds or subtracts the multiplicand according to the {q0, q-1} pair, then performs an arithmetic right shift of the whole register by 1.
  - The result is the full signed 64-bit product.
- DIV: restoring division on magnitudes.
  - |dividend| and |divisor| are taken at accept, as unsigned 32-bit values; |−2^31| = 0x80000000.
  - Each step: shift {rem, quot} left by 1, trial-subtract the divisor from rem (33-bit compare), restore on a negative result, set the quotient bit otherwise.
- FIX: applies the result signs.
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder is negated when the dividend is negative.
  - Truncation is toward zero.
  - −2^31 / −1 gives quotient 0x80000000 and remainder 0 (wraps; no overflow flag).
- DONE: `hi_out`/`lo_out` are updated from the result registers, and `done`, `hi_load` and `lo_load` are asserted for exactly this cycle.
- DZ: `div_zero` is asserted for one cycle.
  - No `done`, `hi_load` or `lo_load`.
  - `hi_out`/`lo_out` are unchanged.
- `start` while not IDLE is ignored; no queuing.
- `op`, `src_a` and `src_b` are don't-care except in the accepting cycle.
- `hi_out`/`lo_out` are registered and hold the last completed result until the next DONE.

## Timing
- Reset (`reset`=0, asynchronous):
  - State is IDLE; counter is 0.
  - All working registers are 0.
  - `busy`, `done`, `hi_load`, `lo_load` and `div_zero` are 0.
  - `hi_out` and `lo_out` are 0.
- Reset asserted mid-operation aborts immediately: no strobe is produced and `hi_out`/`lo_out` are cleared.
- Let cycle 0 be the cycle in which `start` is sampled high.
- MULT:
  - Steps run in cycles 1..32.
  - DONE is cycle 33: `done`=1 and results are valid.
  - `busy`=1 in cycles 1..33.
- DIV:
  - Steps run in cycles 1..32, FIX in cycle 33.
  - DONE is cycle 34.
  - `busy`=1 in cycles 1..34.
- Divide by zero: DZ is cycle 1 with `div_zero`=1 and `busy`=1; IDLE in cycle 2.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE or DZ (cycle 34 for MULT, cycle 35 for DIV, cycle 2 for divide by zero).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3): `done` in cycle 33, `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB, `hi_load`=`lo_load`=1 for one cycle, `busy` 1 in cycles 1..33.
- MULT 0x80000000 × 0x80000000 gives `hi_out`=0x40000000, `lo_out`=0; MULT 0xFFFFFFFF × 0xFFFFFFFF gives `hi_out`=0, `lo_out`=1.
- DIV 0xFFFFFFF9 (−7) / 2: `done` in cycle 34, `lo_out`=0xFFFFFFFD (−3), `hi_out`=0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE (−2) gives `lo_out`=0xFFFFFFFD, `hi_out`=1.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo_out`=0x80000000, `hi_out`=0. DIV 5 / 0: `div_zero`=1 in cycle 1 only, no `done`/loads, `hi_out`/`lo_out` keep their previous values, back in IDLE in cycle 2.
- `start` pulsed in cycles 5 and 20 of a running MULT: both are ignored and a single `done` is produced in cycle 33. A `start` in cycle 34 is accepted.
- `reset` driven low in cycle 10 of a DIV: `busy`=0 and `hi_out`=`lo_out`=0 immediately. After release, no `done` appears, and a fresh MULT 3 × 4 returns `lo_out`=12, `hi_out`=0.
